// File: rtl/clk_mon_pkg.sv
// Shared types and helpers for the clock frequency monitor.
package clk_mon_pkg;

  typedef logic [1:0] state_t;

  localparam state_t IDLE    = 2'd0;
  localparam state_t SETTLE  = 2'd1;
  localparam state_t MEASURE = 2'd2;

  // Settle long enough to flush the synchronizer plus the edge-detect flop.
  function automatic int settle_len(input int sync_stages);
    return sync_stages + 1;
  endfunction

endpackage

// File: rtl/bit_sync.sv
// N-stage single-bit synchronizer with async active-low reset.
module bit_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= '0;
    else        sync_q <= {sync_q[STAGES-2:0], d};
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/clk_freq_monitor.sv
// Counts synchronized rising edges of mon_clk over fixed windows of clk cycles
// and flags slow, fast or stopped clocks at each window end.
module clk_freq_monitor
  import clk_mon_pkg::*;
#(
  parameter int WINDOW_CYCLES = 1000,
  parameter int CNT_W         = 16,
  parameter int SYNC_STAGES   = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             mon_clk,
  input  logic [CNT_W-1:0] cfg_min,
  input  logic [CNT_W-1:0] cfg_max,
  input  logic             err_clr,
  output logic [CNT_W-1:0] meas_count,
  output logic             meas_valid,
  output logic             too_slow,
  output logic             too_fast,
  output logic             clk_dead,
  output logic             err_sticky
);

  localparam int WIN_W      = $clog2(WINDOW_CYCLES);
  localparam int SETTLE_LEN = settle_len(SYNC_STAGES);
  localparam int SET_W      = $clog2(SETTLE_LEN + 1);

  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW_CYCLES - 1);
  localparam logic [SET_W-1:0] SET_LAST = SET_W'(SETTLE_LEN - 1);

  logic             sync_out, sync_prev, rise;
  state_t           state;
  logic [SET_W-1:0] settle_cnt;
  logic [WIN_W-1:0] win_cnt;
  logic [CNT_W-1:0] edge_cnt, final_cnt;
  logic             term, slow_nxt, fast_nxt;

  bit_sync #(.STAGES(SYNC_STAGES)) u_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (mon_clk),
    .q    (sync_out)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_prev <= 1'b0;
    else        sync_prev <= sync_out;
  end

  assign rise = sync_out & ~sync_prev;

  // Saturating count including a rise landing in the current cycle.
  assign final_cnt = (rise && (edge_cnt != '1)) ? edge_cnt + CNT_W'(1) : edge_cnt;
  assign term      = enable && (state == MEASURE) && (win_cnt == WIN_LAST);
  assign slow_nxt  = final_cnt < cfg_min;
  assign fast_nxt  = final_cnt > cfg_max;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      settle_cnt <= '0;
      win_cnt    <= '0;
      edge_cnt   <= '0;
      meas_count <= '0;
      meas_valid <= 1'b0;
      too_slow   <= 1'b0;
      too_fast   <= 1'b0;
      clk_dead   <= 1'b0;
    end else begin
      meas_valid <= 1'b0;
      if (!enable) begin
        // Partial window is dropped; results hold.
        state      <= IDLE;
        settle_cnt <= '0;
        win_cnt    <= '0;
        edge_cnt   <= '0;
      end else begin
        case (state)
          IDLE: begin
            state      <= SETTLE;
            settle_cnt <= '0;
          end
          SETTLE: begin
            if (settle_cnt == SET_LAST) begin
              state    <= MEASURE;
              win_cnt  <= '0;
              edge_cnt <= '0;
            end else begin
              settle_cnt <= settle_cnt + SET_W'(1);
            end
          end
          MEASURE: begin
            if (win_cnt == WIN_LAST) begin
              meas_count <= final_cnt;
              meas_valid <= 1'b1;
              too_slow   <= slow_nxt;
              too_fast   <= fast_nxt;
              clk_dead   <= (final_cnt == '0);
              win_cnt    <= '0;
              edge_cnt   <= '0;
            end else begin
              win_cnt  <= win_cnt + WIN_W'(1);
              edge_cnt <= final_cnt;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  // A failing window beats a coincident clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                         err_sticky <= 1'b0;
    else if (term && (slow_nxt | fast_nxt)) err_sticky <= 1'b1;
    else if (err_clr)                   err_sticky <= 1'b0;
  end

endmodule

// File: tb/tb_clk_freq_monitor.sv
// Scoreboard bench: a window-timeline model predicts each result, a monitor checks it.
module tb_clk_freq_monitor;

  localparam int W  = 1000;
  localparam int CW = 8;
  localparam int S  = 2;

  logic          clk, rst_n, enable, mon_clk, err_clr;
  logic [CW-1:0] cfg_min, cfg_max, meas_count;
  logic          meas_valid, too_slow, too_fast, clk_dead, err_sticky;

  clk_freq_monitor #(.WINDOW_CYCLES(W), .CNT_W(CW), .SYNC_STAGES(S)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .enable    (enable),
    .mon_clk   (mon_clk),
    .cfg_min   (cfg_min),
    .cfg_max   (cfg_max),
    .err_clr   (err_clr),
    .meas_count(meas_count),
    .meas_valid(meas_valid),
    .too_slow  (too_slow),
    .too_fast  (too_fast),
    .clk_dead  (clk_dead),
    .err_sticky(err_sticky)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int cnt;
    bit slow;
    bit fast;
    bit dead;
    int cyc;
  } exp_t;

  exp_t     exp_q[$];
  int       checks = 0;
  int       errors = 0;
  int       cyc = 0;
  int       mode = 1;  // 0 stopped, 1 nominal 40ns, 2 random phases, 3 30ns
  int       start = 0;
  int       cnt = 0;
  bit       active = 0;
  bit       msticky = 0;
  logic [7:0] samp = '0;
  logic [11:0] last = '0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitored clock: levels change on negedge only, each phase >= 1 cycle, period >= 3.
  initial begin
    int ph;
    mon_clk = 1'b0;
    ph = 1;
    forever begin
      @(negedge clk);
      if (mode == 0) mon_clk = 1'b0;
      else if (ph > 1) ph--;
      else begin
        mon_clk = ~mon_clk;
        case (mode)
          1:       ph = 2;
          2:       ph = mon_clk ? $urandom_range(1, 3) : $urandom_range(2, 3);
          default: ph = mon_clk ? 1 : 2;
        endcase
      end
    end
  end

  // Reference model: a rise seen at sample edge n is credited to the FSM cycle
  // ending at edge n+S; windows of W cycles follow S+1 settle cycles after enable.
  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      if (!rst_n) begin
        samp    = '0;
        active  = 0;
        msticky = 0;
        exp_q.delete();
      end else begin
        bit credit, failed;
        failed = 0;
        samp   = {samp[6:0], mon_clk};
        credit = samp[S] & ~samp[S+1];
        if (!enable) active = 0;
        else if (!active) begin
          active = 1;
          start  = cyc + S + 1;
          cnt    = 0;
        end else if (cyc > start) begin
          if (credit) cnt++;
          if (cyc == start + W) begin
            exp_t e;
            e.cnt  = (cnt > 255) ? 255 : cnt;
            e.slow = e.cnt < int'(cfg_min);
            e.fast = e.cnt > int'(cfg_max);
            e.dead = (e.cnt == 0);
            e.cyc  = cyc;
            exp_q.push_back(e);
            failed = e.slow | e.fast;
            start  = cyc;
            cnt    = 0;
          end
        end
        if (failed) msticky = 1;
        else if (err_clr) msticky = 0;
      end
    end
  end

  // Monitor: pops on every meas_valid and checks held outputs every cycle.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) last = '0;
      else begin
        if (meas_valid) begin
          if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_valid: got meas_valid=1 expected 0 (cycle %0d)", cyc);
          end else begin
            exp_t e;
            e = exp_q.pop_front();
            chk("count", meas_count, e.cnt);
            chk("too_slow", too_slow, e.slow);
            chk("too_fast", too_fast, e.fast);
            chk("clk_dead", clk_dead, e.dead);
            chk("valid_cycle", cyc, e.cyc);
            last = {CW'(e.cnt), e.slow, e.fast, e.dead, 1'b0};
          end
        end else if (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
          checks++; errors++;
          $display("FAIL missed_valid: got none expected at cycle %0d", exp_q[0].cyc);
          void'(exp_q.pop_front());
        end
        chk("held_outputs", {meas_count, too_slow, too_fast, clk_dead, err_sticky},
            {last[11:1], msticky});
      end
    end
  end

  task automatic run_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      err_clr = ($urandom_range(0, 199) == 0);
    end
    @(negedge clk);
    err_clr = 1'b0;
  endtask

  // Leaves the bench at the negedge just before a terminal edge.
  task automatic wait_term();
    int n = 0;
    @(negedge clk);
    while (!(active && cyc == start + W - 1) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk("wait_term_timeout", n < 3000, 1);
  endtask

  task automatic wait_valid(input int lim, output int at);
    at = -1;
    for (int i = 0; i < lim; i++) begin
      @(negedge clk);
      if (meas_valid) begin
        at = cyc;
        break;
      end
    end
  endtask

  initial begin
    int at, en_edge, n;
    rst_n = 1'b1; enable = 1'b0; err_clr = 1'b0;
    cfg_min = 8'd240; cfg_max = 8'd254;
    #2 rst_n = 1'b0;
    repeat (4) @(negedge clk);
    chk("rst_count", meas_count, 0);
    chk("rst_valid", meas_valid, 0);
    chk("rst_flags", {too_slow, too_fast, clk_dead}, 0);
    chk("rst_sticky", err_sticky, 0);

    // Nominal 40 ns clock.
    rst_n = 1'b1; enable = 1'b1; mode = 1;
    run_cycles(3 * W + 100);
    chk("nominal_sticky", err_sticky, 0);

    // Randomized clocks and thresholds.
    for (int k = 0; k < 6; k++) begin
      mode    = $urandom_range(1, 2);
      cfg_min = 8'($urandom_range(0, 255));
      cfg_max = 8'($urandom_range(0, 255));
      run_cycles($urandom_range(W / 2, 2 * W));
    end

    // Stopped clock, then restored: sticky must survive.
    cfg_min = 8'd240; cfg_max = 8'd254; err_clr = 1'b0;
    @(negedge clk); err_clr = 1'b1; @(negedge clk); err_clr = 1'b0;
    mode = 0;
    wait_term(); wait_term();
    @(negedge clk);
    chk("dead_flag", clk_dead, 1);
    chk("dead_slow", too_slow, 1);
    mode = 1;
    wait_term(); wait_term();
    @(negedge clk);
    chk("restored_dead", clk_dead, 0);
    chk("sticky_held", err_sticky, 1);

    // err_clr on a failing terminal edge: set wins.
    mode = 0;
    wait_term();
    err_clr = 1'b1; @(negedge clk); err_clr = 1'b0;
    chk("set_wins", err_sticky, 1);
    // err_clr on a passing terminal edge clears.
    mode = 1;
    wait_term(); wait_term();
    err_clr = 1'b1; @(negedge clk); err_clr = 1'b0;
    chk("clr_on_pass", err_sticky, 0);

    // Fast clock saturates rather than wrapping.
    mode = 3; cfg_max = 8'd200;
    wait_term(); wait_term();
    @(negedge clk);
    chk("sat_count", meas_count, 255);
    chk("sat_fast", too_fast, 1);

    // Enable drop mid-window, then re-enable.
    mode = 1; cfg_max = 8'd254;
    n = 0;
    while (!(active && cyc == start + 500) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    enable = 1'b0;
    run_cycles(20);
    enable  = 1'b1;
    en_edge = cyc + 1;
    wait_valid(2 * W, at);
    chk("reenable_latency", at, en_edge + S + 1 + W);

    // Async reset mid-window, off a clock edge.
    run_cycles(300);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("async_rst_count", meas_count, 0);
    chk("async_rst_flags", {too_slow, too_fast, clk_dead, err_sticky, meas_valid}, 0);
    repeat (3) @(negedge clk);
    rst_n   = 1'b1;
    en_edge = cyc + 1;
    wait_valid(2 * W, at);
    chk("post_rst_latency", at, en_edge + S + 1 + W);

    repeat (5) @(negedge clk);
    chk("queue_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/clk_freq_monitor.md
Name: clk_freq_monitor

Overview:
Measures a buffered clock by treating it as asynchronous data. The monitored clock (`mon_clk`), e.g. the output of the clock buffer, is sampled in the reference clock domain, and its rising edges are counted over a fixed window of reference cycles. At each window end the block reports the edge count and flags a clock that is too slow, too fast or stopped. It is the receiving/checking end of the clock-distribution path and is used in the SoC and in clock-tree bring-up benches.

Parameters:
- WINDOW_CYCLES, 1000: reference `clk` cycles per measurement window; must be ≥ 4.
- CNT_W, 16: width of the edge counter and of the config/result ports.
- SYNC_STAGES, 2: synchronizer depth on `mon_clk`; must be ≥ 2.

Ports:
- clk  in  1  reference clock; the only clock of the block.
- rst_n  in  1  asynchronous, active-low reset.
- enable  in  1  level; 1 = measure continuously, 0 = idle.
- mon_clk  in  1  monitored clock, asynchronous to `clk`, treated as data.
- cfg_min  in  CNT_W  minimum acceptable edges per window.
- cfg_max  in  CNT_W  maximum acceptable edges per window.
- err_clr  in  1  single-cycle pulse; clears `err_sticky`.
- meas_count  out  CNT_W  edge count of the last completed window.
- meas_valid  out  1  one-cycle pulse when `meas_count` and the flags update.
- too_slow  out  1  last window count < `cfg_min`.
- too_fast  out  1  last window count > `cfg_max`.
- clk_dead  out  1  last window count == 0.
- err_sticky  out  1  set by any window with `too_slow` or `too_fast`; held until `err_clr`.

Behaviour:
- **Reset:** all outputs 0, FSM in IDLE, synchronizer, window counter and edge counter all 0.
- **Synchronizer:** `mon_clk` passes through SYNC_STAGES flops, plus one flop for edge detection.
  - `rise` = sync_out & ~sync_prev.
  - Latency from a `mon_clk` rising edge to `rise` is SYNC_STAGES+1 cycles.
  - Exact counting requires the `mon_clk` period ≥ 3 `clk` periods and each phase ≥ 1 `clk` period. Faster clocks undercount; this is a documented limitation, not an error.
- **FSM states: IDLE, SETTLE, MEASURE.**
  - IDLE: counters held at 0. `enable`=1 → SETTLE.
  - SETTLE: lasts SYNC_STAGES+1 cycles to flush the synchronizer. `rise` is ignored. Then → MEASURE with win_cnt=0 and edge_cnt=0.
  - MEASURE: win_cnt increments every cycle. edge_cnt increments on `rise` and saturates at 2^CNT_W−1, with no wrap.
  - Terminal cycle is win_cnt == WINDOW_CYCLES−1. On it, a `rise` occurring in that cycle is included in the result.
  - On the next edge after the terminal cycle: `meas_count` ← final count, `meas_valid`=1 for one cycle, flags are updated, and win_cnt and edge_cnt restart at 0. The FSM stays in MEASURE, so windows run back-to-back with no gap and no lost edges.
- **Flags:** registered together with `meas_count` and held between windows.
  - `too_slow` = count < `cfg_min`.
  - `too_fast` = count > `cfg_max`.
  - `clk_dead` = (count == 0).
  - `cfg_min`/`cfg_max` are sampled only in the terminal cycle. If `cfg_min` > `cfg_max`, both flags may assert; this is allowed.
- **err_sticky:** set on the `meas_valid` cycle if `too_slow` | `too_fast` is being loaded. Otherwise cleared by `err_clr`. If set and clear occur in the same cycle, set wins.
- **enable drop:** `enable`=0 in any state → IDLE next cycle. The partial window is discarded with no `meas_valid`. `meas_count`, flags and `err_sticky` hold their values. Re-enabling goes through SETTLE again.
- **Reset mid-window:** immediate return to the reset state. No `meas_valid` is generated.
- **Width rules:** win_cnt width is $clog2(WINDOW_CYCLES). All comparisons are unsigned, CNT_W bits.

Decomposition:
- Package `clk_mon_pkg`: FSM state enum (IDLE/SETTLE/MEASURE) and the function that computes the settle length from SYNC_STAGES.
- One sub-module, `bit_sync`: an N-stage single-bit synchronizer parameterized by SYNC_STAGES with async active-low reset. It is reusable across the codebase.
- Edge detection, counters, FSM and flags remain in the top module.

Test Plan:
1. Nominal: clk 10 ns, `mon_clk` 40 ns, WINDOW_CYCLES=1000, `cfg_min`=240, `cfg_max`=260 → `meas_valid` every 1000 cycles, `meas_count` ∈ {249, 250, 251}, all flags 0, `err_sticky`=0.
2. Stopped clock: hold `mon_clk`=0 → next window gives `meas_count`=0 with `clk_dead`=1, `too_slow`=1, `err_sticky`=1. Restoring the 40 ns clock → the next window clears `clk_dead`/`too_slow`, but `err_sticky` stays 1 until an `err_clr` pulse.
3. Fast clock plus saturation: `mon_clk` 30 ns, CNT_W=8 → raw count ≈ 333 saturates, so `meas_count`=255 and `too_fast`=1 (`cfg_max`=200). No wrap to a small value.
4. Enable drop: deassert `enable` at cycle 500 of a window → no `meas_valid`, outputs hold. Reassert → first `meas_valid` arrives exactly SYNC_STAGES+1+1000 cycles later.
5. Simultaneous events: `err_clr` pulse on the same cycle as a failing `meas_valid` → `err_sticky`=1. `err_clr` on a passing window → `err_sticky`=0.
6. Async reset asserted mid-window, off a `clk` edge → all outputs 0 immediately. After release and with `enable`=1, the first `meas_valid` comes after the full SETTLE + window time.
